// File: rtl/flag_pkg.sv
// flag_pkg: shared types and constants for the LEGv8 condition-flag controller.
`default_nettype none
package flag_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_type_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001,
    COND_HS = 4'b0010, COND_LO = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101,
    COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001,
    COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101,
    COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [0:0] state_t;
  localparam state_t RUN  = 1'b0;
  localparam state_t HOLD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/flag_ctrl_if.sv
// flag_ctrl_if: ALU-flag, decode-branch and resolution signals of the flag controller.
`default_nettype none
interface flag_ctrl_if;
  logic       ex_valid;
  logic       ex_setflags;
  logic       alu_negative;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_overflow;
  logic [1:0] id_br_type;
  logic [3:0] id_cond;
  logic       id_reg_zero;
  logic       flush;
  logic       stall;
  logic       br_valid;
  logic       br_taken;
  logic [3:0] flags;

  modport master (
    output ex_valid, ex_setflags, alu_negative, alu_zero, alu_carry, alu_overflow,
    output id_br_type, id_cond, id_reg_zero, flush,
    input  stall, br_valid, br_taken, flags
  );

  modport slave (
    input  ex_valid, ex_setflags, alu_negative, alu_zero, alu_carry, alu_overflow,
    input  id_br_type, id_cond, id_reg_zero, flush,
    output stall, br_valid, br_taken, flags
  );
endinterface
`default_nettype wire

// File: rtl/flag_ctrl_cond_eval.sv
// cond_eval: combinational B.cond predicate over {N,Z,C,V}.
`default_nettype none
module cond_eval
  import flag_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic n, z, c, v;
  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    taken_o = 1'b1;
    case (cond_t'(cond_i))
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_HS: taken_o = c;
      COND_LO: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = c & !z;
      COND_LS: taken_o = !c | z;
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z & (n == v);
      COND_LE: taken_o = z | (n != v);
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/flag_ctrl.sv
// flag_ctrl: NZCV register, branch resolution and flag-hazard stall for LEGv8.
// FLAG_FWD_EN: resolve hazard B.cond from live ALU flags instead of stalling.
`default_nettype none
module flag_ctrl
  import flag_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  flag_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  logic [3:0] flags_q;
  logic       br_valid_q, br_taken_q;

  logic       setf, hazard, hold_req, stall_c, resolved, taken_c, cond_taken;
  logic [3:0] alu_flags, eval_flags;
  br_type_t   br_type;

  assign setf      = bus.ex_valid & bus.ex_setflags;
  assign alu_flags = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
  assign br_type   = br_type_t'(bus.id_br_type);
  assign hazard    = (br_type == BR_COND) & setf;

`ifdef FLAG_FWD_EN
  assign eval_flags = hazard ? alu_flags : flags_q;
  assign hold_req   = 1'b0;
`else
  assign eval_flags = flags_q;
  assign hold_req   = hazard;
`endif

  cond_eval u_cond_eval (
    .cond_i  (bus.id_cond),
    .flags_i (eval_flags),
    .taken_o (cond_taken)
  );

  always_comb begin
    case (br_type)
      BR_COND: taken_c = cond_taken;
      BR_CBZ:  taken_c = bus.id_reg_zero;
      BR_CBNZ: taken_c = !bus.id_reg_zero;
      default: taken_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = RUN;
    stall_c  = 1'b0;
    resolved = 1'b0;
    case (state_q)
      RUN: begin
        if (hold_req) begin
          state_d = HOLD;
          stall_c = 1'b1;
        end else begin
          resolved = (br_type != BR_NONE);
        end
      end
      HOLD: begin
        // Flags were refreshed last edge; only a fresh setflags in EX re-stalls.
        if (hold_req) begin
          state_d = HOLD;
          stall_c = 1'b1;
        end else begin
          resolved = (br_type != BR_NONE);
        end
      end
      default: state_d = RUN;
    endcase
    if (bus.flush) begin
      state_d = RUN;
      stall_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      flags_q    <= 4'b0000;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (setf) flags_q <= alu_flags;
      br_valid_q <= resolved & !bus.flush;
      br_taken_q <= resolved & taken_c & !bus.flush;
    end
  end

  assign bus.stall    = stall_c & !reset;
  assign bus.br_valid = br_valid_q;
  assign bus.br_taken = br_taken_q;
  assign bus.flags    = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: directed self-checking bench for flag_ctrl.
`default_nettype none
module tb_flag_ctrl;
  import flag_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  flag_ctrl_if bus ();

  flag_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic s, input logic [3:0] f);
    bus.ex_valid     = v;
    bus.ex_setflags  = s;
    bus.alu_negative = f[3];
    bus.alu_zero     = f[2];
    bus.alu_carry    = f[1];
    bus.alu_overflow = f[0];
  endtask

  task automatic set_br(input logic [1:0] t, input logic [3:0] c, input logic rz);
    bus.id_br_type  = t;
    bus.id_cond     = c;
    bus.id_reg_zero = rz;
  endtask

  task automatic load_flags(input logic [3:0] f);
    set_ex(1'b1, 1'b1, f);
    set_br(2'b00, 4'h0, 1'b0);
    step();
    set_ex(1'b0, 1'b0, 4'h0);
    chk("load_flags", bus.flags, f);
  endtask

  // Sweep all 16 conditions against the current flags; mask bit i = taken for cond i.
  task automatic sweep(input string tag, input logic [15:0] mask);
    for (int c = 0; c < 16; c++) begin
      set_br(2'b01, 4'(c), 1'b0);
      #1;
      chk({tag, "_stall"}, {3'b0, bus.stall}, 4'b0);
      step();
      chk({tag, "_vt"}, {2'b0, bus.br_valid, bus.br_taken}, {2'b0, 1'b1, mask[c]});
    end
    set_br(2'b00, 4'h0, 1'b0);
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.flush = 1'b0;
    set_ex(1'b1, 1'b1, 4'b1111);
    set_br(2'b01, 4'b0000, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", bus.flags, 4'b0000);
    chk("reset_brv", {3'b0, bus.br_valid}, 4'b0);
    chk("reset_stall", {3'b0, bus.stall}, 4'b0);
    set_ex(1'b0, 1'b0, 4'h0);
    set_br(2'b00, 4'h0, 1'b0);
    reset = 1'b0;
    step();

    // Flag capture, then a no-hazard B.cond EQ.
    set_ex(1'b1, 1'b1, 4'b0110);
    step();
    chk("cap_flags", bus.flags, 4'b0110);
    chk("cap_brv", {3'b0, bus.br_valid}, 4'b0);
    set_ex(1'b0, 1'b0, 4'h0);
    set_br(2'b01, 4'b0000, 1'b0);
    #1;
    chk("eq_stall", {3'b0, bus.stall}, 4'b0);
    step();
    chk("eq_vt", {2'b0, bus.br_valid, bus.br_taken}, 4'b0011);
    set_br(2'b00, 4'h0, 1'b0);
    step();
    chk("eq_once", {3'b0, bus.br_valid}, 4'b0);

    // Flag-write gating.
    set_ex(1'b1, 1'b0, 4'b1001);
    step();
    chk("no_setf", bus.flags, 4'b0110);
    set_ex(1'b0, 1'b1, 4'b1001);
    step();
    chk("no_valid", bus.flags, 4'b0110);

    // Hazard: SUBS gives Z=1 while B.cond NE sits in decode.
    load_flags(4'b0000);
    set_ex(1'b1, 1'b1, 4'b0100);
    set_br(2'b01, 4'b0001, 1'b0);
    #1;
`ifdef FLAG_FWD_EN
    chk("haz_stall", {3'b0, bus.stall}, 4'b0);
    step();
    set_ex(1'b0, 1'b0, 4'h0);
    chk("haz_vt", {2'b0, bus.br_valid, bus.br_taken}, 4'b0010);
`else
    chk("haz_stall", {3'b0, bus.stall}, 4'b1);
    step();
    set_ex(1'b0, 1'b0, 4'h0);
    #1;
    chk("haz_n1_flags", bus.flags, 4'b0100);
    chk("haz_n1_brv", {3'b0, bus.br_valid}, 4'b0);
    chk("hold_stall", {3'b0, bus.stall}, 4'b0);
    step();
    chk("haz_vt", {2'b0, bus.br_valid, bus.br_taken}, 4'b0010);
`endif
    set_br(2'b00, 4'h0, 1'b0);
    step();
    chk("haz_once", {3'b0, bus.br_valid}, 4'b0);

    // Reset pulsed while in HOLD (hazard still present on inputs).
    set_ex(1'b1, 1'b1, 4'b1000);
    set_br(2'b01, 4'b1010, 1'b0);
    step();
    reset = 1'b1;
    #1;
    chk("rhold_flags", bus.flags, 4'b0000);
    chk("rhold_brv", {3'b0, bus.br_valid}, 4'b0);
    chk("rhold_stall", {3'b0, bus.stall}, 4'b0);
    step();
    chk("rhold_flags2", bus.flags, 4'b0000);
    set_ex(1'b0, 1'b0, 4'h0);
    set_br(2'b01, 4'b0000, 1'b0);
    reset = 1'b0;
    #1;
    chk("rrel_stall", {3'b0, bus.stall}, 4'b0);
    step();
    chk("rrel_vt", {2'b0, bus.br_valid, bus.br_taken}, 4'b0010);
    set_br(2'b00, 4'h0, 1'b0);
    step();

    // Full condition table under three flag patterns.
    load_flags(4'b1000);
    sweep("n1", 16'hEA9A);
    load_flags(4'b0111);
    sweep("zcv", 16'hEA65);
    load_flags(4'b0010);
    sweep("c1", 16'hD5A6);

    // CBZ/CBNZ ignore flags and never stall, even with setflags in EX.
    set_ex(1'b1, 1'b1, 4'b0100);
    set_br(2'b10, 4'h0, 1'b1);
    #1;
    chk("cbz_stall", {3'b0, bus.stall}, 4'b0);
    step();
    chk("cbz_rz1", {2'b0, bus.br_valid, bus.br_taken}, 4'b0011);
    set_br(2'b11, 4'h0, 1'b1);
    #1;
    chk("cbnz_stall", {3'b0, bus.stall}, 4'b0);
    step();
    chk("cbnz_rz1", {2'b0, bus.br_valid, bus.br_taken}, 4'b0010);
    set_br(2'b11, 4'h0, 1'b0);
    step();
    chk("cbnz_rz0", {2'b0, bus.br_valid, bus.br_taken}, 4'b0011);
    set_br(2'b10, 4'h0, 1'b0);
    step();
    chk("cbz_rz0", {2'b0, bus.br_valid, bus.br_taken}, 4'b0010);

    // Flush on a hazard B.cond: no stall, no branch, flags still written.
    set_ex(1'b1, 1'b1, 4'b0101);
    set_br(2'b01, 4'b1110, 1'b0);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", {3'b0, bus.stall}, 4'b0);
    step();
    chk("flush_brv", {3'b0, bus.br_valid}, 4'b0);
    chk("flush_flags", bus.flags, 4'b0101);
    bus.flush = 1'b0;
    set_ex(1'b0, 1'b0, 4'h0);
    set_br(2'b00, 4'h0, 1'b0);
    #1;
    chk("flush_after_stall", {3'b0, bus.stall}, 4'b0);
    step();
    chk("flush_after_brv", {3'b0, bus.br_valid}, 4'b0);

    // Flush of a plain no-hazard branch.
    set_br(2'b01, 4'b1110, 1'b0);
    bus.flush = 1'b1;
    step();
    chk("flush_nohaz", {2'b0, bus.br_valid, bus.br_taken}, 4'b0000);
    bus.flush = 1'b0;
    set_br(2'b00, 4'h0, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
